// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB initiator: FSM states, slave address map,
// select encodings and the default wait-state timeout.
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_t;

   localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
   localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
   localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
   localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
   localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
   localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

   localparam logic [2:0] SEL_NONE = 3'b000;
   localparam logic [2:0] SEL_S0   = 3'b001;
   localparam logic [2:0] SEL_S1   = 3'b010;
   localparam logic [2:0] SEL_S2   = 3'b100;

   localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps a request address to a one-hot slave select.
module apb_addr_decode
   import apb_bridge_pkg::*;
(
   input  logic [31:0] addr,
   output logic [2:0]  Pselx,
   output logic        hit
);

   always_comb begin
      Pselx = SEL_NONE;
      if (addr >= SLV0_BASE && addr <= SLV0_LIMIT)
         Pselx = SEL_S0;
      else if (addr >= SLV1_BASE && addr <= SLV1_LIMIT)
         Pselx = SEL_S1;
      else if (addr >= SLV2_BASE && addr <= SLV2_LIMIT)
         Pselx = SEL_S2;
      hit = (Pselx != SEL_NONE);
   end

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: accepts one request in IDLE, runs SETUP/ACCESS
// with wait-state timeout, and returns a one-cycle response pulse.
module apb_initiator
   import apb_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [2:0]  Pselx,
   output logic        Penable,
   output logic        Pwrite,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   input  logic [31:0] Prdata,
   input  logic        Pready,
   input  logic        Pslverr
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   apb_state_t       state;
   logic [CNT_W-1:0] wait_cnt;
   logic [2:0]       dec_sel;
   logic             dec_hit;

   apb_addr_decode u_decode (
      .addr  (req_addr),
      .Pselx (dec_sel),
      .hit   (dec_hit)
   );

   assign req_ready = (state == IDLE);

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         Pselx     <= SEL_NONE;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Paddr     <= '0;
         Pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (dec_hit) begin
                     Pwrite <= req_write;
                     Paddr  <= req_addr;
                     Pwdata <= req_wdata;
                     Pselx  <= dec_sel;
                     state  <= SETUP;
                  end else begin
                     // Unmapped address never reaches the bus
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end
               end
            end
            SETUP: begin
               Penable  <= 1'b1;
               wait_cnt <= '0;
               state    <= ACCESS;
            end
            ACCESS: begin
               if (Pready) begin
                  Pselx     <= SEL_NONE;
                  Penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= Pslverr;
                  rsp_rdata <= (!Pwrite && !Pslverr) ? Prdata : '0;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  // Last permitted wait cycle expired: abort the transfer
                  if (wait_cnt == CNT_LAST) begin
                     Pselx     <= SEL_NONE;
                     Penable   <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: randomized requests, an APB slave model
// driven by per-transfer wait/data/error settings, and a decoupled response monitor.
module tb_apb_initiator;

   localparam int TMO = 16;

   logic        Hclk = 1'b0;
   logic        Hresetn;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [2:0]  Pselx;
   logic        Penable, Pwrite, Pready, Pslverr;
   logic [31:0] Paddr, Pwdata, Prdata;

   apb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .Hclk(Hclk), .Hresetn(Hresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
      .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
   );

   always #5 Hclk = ~Hclk;

   int unsigned cyc = 0;
   always @(posedge Hclk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
      logic        err;
   } slv_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned at;
   } exp_t;

   slv_t slv_q[$];
   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   slv_t cur;
   bit   active = 1'b0;
   int   cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [2:0] slave_of(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
      if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
      if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
      return 3'b000;
   endfunction

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input logic [31:0] rd, input bit er,
                       output int unsigned acc);
      int   guard = 0;
      slv_t s;
      exp_t e;
      bit   tmo;
      int   n_access;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      acc = 0;
      while (!req_ready) begin
         @(negedge Hclk);
         guard++;
         if (guard > 100) begin
            check("req_ready_timeout", req_ready, 1);
            return;
         end
      end
      acc = cyc + 1;
      s.sel = slave_of(a);
      if (s.sel == 3'b000) begin
         e.rdata = '0; e.err = 1'b1; e.at = cyc + 1;
      end else begin
         tmo      = (waits >= TMO);
         n_access = tmo ? TMO : waits + 1;
         e.err    = tmo ? 1'b1 : er;
         e.rdata  = (tmo || er || wr) ? 32'h0 : rd;
         e.at     = cyc + 2 + n_access;
         s.addr = a; s.wr = wr; s.wdata = d; s.waits = waits; s.rdata = rd; s.err = er;
         slv_q.push_back(s);
      end
      exp_q.push_back(e);
      @(negedge Hclk);
   endtask

   // APB slave model; Pready/Prdata/Pslverr are randomized outside its own ACCESS
   initial begin
      Pready = 1'b0; Prdata = '0; Pslverr = 1'b0;
      forever begin
         @(negedge Hclk);
         if (Hresetn && Pselx != 3'b000 && !Penable) begin
            if (slv_q.size() == 0) begin
               check("unexpected_setup", Pselx, 0);
               active = 1'b0;
            end else begin
               cur = slv_q.pop_front();
               active = 1'b1;
               cnt = 0;
               check("setup_sel", Pselx, cur.sel);
               check("setup_addr", Paddr, cur.addr);
               check("setup_write", Pwrite, cur.wr);
               if (cur.wr) check("setup_wdata", Pwdata, cur.wdata);
            end
         end
         if (Hresetn && active && Pselx != 3'b000 && Penable) begin
            check("access_hold", {Pselx, Pwrite, Paddr}, {cur.sel, cur.wr, cur.addr});
            if (cur.wr) check("access_wdata", Pwdata, cur.wdata);
            if (cnt < cur.waits) begin
               Pready = 1'b0; Prdata = $urandom; Pslverr = 1'($urandom); cnt++;
            end else begin
               Pready = 1'b1; Prdata = cur.rdata; Pslverr = cur.err; active = 1'b0;
            end
         end else begin
            Pready = 1'($urandom); Prdata = $urandom; Pslverr = 1'($urandom);
         end
      end
   end

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge Hclk);
         if (Hresetn && rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_rsp", rsp_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err", rsp_err, e.err);
               check("rsp_cycle", cyc, e.at);
               check("rsp_bus_idle", {Pselx, Penable}, 0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, got %0d responses pending, required 0", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned acc, prev;
      int sel_cnt, en_cnt, waits, k;
      logic [31:0] a;
      Hresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge Hclk);
      check("reset_outputs", {Pselx, Penable, Pwrite, Paddr, Pwdata, rsp_valid, rsp_rdata, rsp_err}, 0);
      Hresetn = 1'b1;
      @(negedge Hclk);
      check("reset_req_ready", req_ready, 1);

      // Zero-wait write: select for SETUP+ACCESS, enable for ACCESS only
      send(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, acc);
      req_valid = 1'b0;
      sel_cnt = 0; en_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (Pselx == 3'b001) sel_cnt++;
         if (Penable) en_cnt++;
         @(negedge Hclk);
      end
      check("wr_psel_cycles", sel_cnt, 2);
      check("wr_penable_cycles", en_cnt, 1);

      send(1'b0, 32'h8400_0004, 32'h0, 3, 32'h0000_00A5, 1'b0, acc);
      send(1'b0, 32'h9000_0000, 32'h0, 0, 32'h1111_1111, 1'b0, acc);
      send(1'b0, 32'h8800_0000, 32'h0, 20, 32'h1234_5678, 1'b0, acc);
      send(1'b1, 32'h8000_0100, 32'hCAFE_0001, 2, 32'h0, 1'b1, acc);
      send(1'b0, 32'h8400_0000, 32'h0, 0, 32'h5555_AAAA, 1'b1, acc);
      send(1'b0, 32'h83FF_FFFF, 32'h0, 15, 32'hA0A0_0F0F, 1'b0, acc);
      send(1'b0, 32'h8BFF_FFFF, 32'h0, 16, 32'hBEEF_0000, 1'b0, acc);
      send(1'b1, 32'h8C00_0000, 32'h0BAD_0BAD, 0, 32'h0, 1'b0, acc);
      send(1'b0, 32'h7FFF_FFFF, 32'h0, 0, 32'h0, 1'b0, acc);
      req_valid = 1'b0;

      // Reset in the middle of a wait-stated ACCESS
      send(1'b0, 32'h8000_0040, 32'h0, 30, 32'h77, 1'b0, acc);
      req_valid = 1'b0;
      repeat (3) @(negedge Hclk);
      #2 Hresetn = 1'b0;
      #1;
      check("midreset_outputs", {Pselx, Penable, Pwrite, Paddr, Pwdata, rsp_valid, rsp_rdata, rsp_err}, 0);
      exp_q.delete();
      slv_q.delete();
      active = 1'b0;
      #1 Hresetn = 1'b1;
      @(negedge Hclk);

      // Back-to-back zero-wait stream: one acceptance every 4 cycles
      prev = 0;
      for (int i = 0; i < 30; i++) begin
         k = $urandom_range(0, 2);
         a = 32'h8000_0000 + (k << 26) + ($urandom & 32'h03FF_FFFF);
         send(1'($urandom), a, $urandom, 0, $urandom, 1'b0, acc);
         if (i > 0) check("b2b_spacing", acc - prev, 4);
         prev = acc;
      end
      req_valid = 1'b0;

      // Randomized mix of hits, misses, waits, errors and idle gaps
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 5);
         if (k <= 2)      a = 32'h8000_0000 + (k << 26) + ($urandom & 32'h03FF_FFFF);
         else if (k == 3) a = $urandom;
         else if (k == 4) a = ($urandom_range(0, 1) == 1) ? 32'h8BFF_FFFF : 32'h8C00_0000;
         else             a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFC;
         waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
         send(1'($urandom), a, $urandom, waits, $urandom, ($urandom_range(0, 3) == 0), acc);
         if ($urandom_range(0, 1) == 1) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge Hclk);
         end
      end
      req_valid = 1'b0;

      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge Hclk);
      repeat (3) @(negedge Hclk);
      check("drain_responses", exp_q.size(), 0);
      check("drain_slave_cfg", slv_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
